// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : shared types and constants for the UART receive path            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_ODD  = 2'b11;

  localparam int RX_PERR_BIT     = 9;
  localparam int RX_FERR_BIT     = 8;
  localparam int RX_ENTRY_W      = 10;
  localparam int RX_TIMEOUT_BITS = 40;

  // Shift register fills from the top; move an N-bit word down to bit 0.
  function automatic logic [7:0] align_data(input logic [7:0] sh, input logic [1:0] bits);
    return sh >> (3'd3 - {1'b0, bits});
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_fifo : first-word-fall-through FIFO, simultaneous push/pop allowed    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);
  localparam logic [c_cw-1:0] c_full_lvl = c_cw'(DEPTH);
  localparam logic [c_aw-1:0] c_last_ptr = c_aw'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != c_full_lvl) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_aw'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_aw'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + c_cw'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - c_cw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_full_lvl);

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_core : oversampled UART receiver with error tagging and FWFT FIFO  |
// | Optional receive timeout: define UART_RX_TIMEOUT_EN.   Rev 1.0             |
// +----------------------------------------------------------------------------+
module uart_rx_core import uart_pkg::*; #(
  parameter int DEPTH       = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic                        rx,
  input  logic [15:0]                 cfg_clk_div,
  input  logic [1:0]                  cfg_data_bits,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic [$clog2(DEPTH+1)-1:0]  cfg_irq_thresh,
  input  logic                        rd_en,
  output logic [9:0]                  rd_data,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        empty,
  output logic                        full,
  output logic                        overrun,
  input  logic                        clr_overrun,
  output logic                        timeout,
  output logic                        irq
);

  localparam int c_tw = $clog2(OVERSAMPLE);
  localparam logic [c_tw-1:0] c_smp0 = c_tw'(OVERSAMPLE/2 - 1);
  localparam logic [c_tw-1:0] c_smp1 = c_tw'(OVERSAMPLE/2);
  localparam logic [c_tw-1:0] c_smp2 = c_tw'(OVERSAMPLE/2 + 1);
  localparam logic [c_tw-1:0] c_tlast = c_tw'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx;
  rx_state_e              r_state;
  logic [15:0]            r_clk_div;
  logic [1:0]             r_bits;
  logic [1:0]             r_par;
  logic                   r_stop2;
  logic [15:0]            r_div;
  logic [c_tw-1:0]        r_tcnt;
  logic                   r_s0;
  logic                   r_s1;
  logic [7:0]             r_shift;
  logic [2:0]             r_bitcnt;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_overrun;
  logic                   w_tick;
  logic                   w_maj;
  logic                   w_decide;
  logic                   w_bit_end;
  logic                   w_push;
  logic [RX_ENTRY_W-1:0]  w_entry;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= rx;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end
  assign w_rx = r_sync[SYNC_STAGES-1];

  assign w_tick    = (r_state != ST_IDLE) && (r_div == r_clk_div);
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_decide  = w_tick && (r_tcnt == c_smp2);
  assign w_bit_end = w_tick && (r_tcnt == c_tlast);
  assign w_push    = w_decide && ((r_state == ST_STOP2) || ((r_state == ST_STOP1) && !r_stop2));

  // r_ferr is still clear in STOP1, so one expression covers both stop bits.
  always_comb begin
    w_entry              = '0;
    w_entry[7:0]         = align_data(r_shift, r_bits);
    w_entry[RX_FERR_BIT] = r_ferr | ~w_maj;
    w_entry[RX_PERR_BIT] = r_perr;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_div  <= '0;
      r_tcnt <= '0;
      r_s0   <= 1'b1;
      r_s1   <= 1'b1;
    end else if (r_state == ST_IDLE) begin
      r_div  <= '0;
      r_tcnt <= '0;
    end else begin
      r_div <= (r_div == r_clk_div) ? '0 : r_div + 16'd1;
      if (w_tick) begin
        r_tcnt <= (r_tcnt == c_tlast) ? '0 : r_tcnt + c_tw'(1);
        if (r_tcnt == c_smp0) r_s0 <= w_rx;
        if (r_tcnt == c_smp1) r_s1 <= w_rx;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state   <= ST_IDLE;
      r_clk_div <= '0;
      r_bits    <= '0;
      r_par     <= PAR_NONE;
      r_stop2   <= 1'b0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rx) begin
            r_clk_div <= cfg_clk_div;
            r_bits    <= cfg_data_bits;
            r_par     <= cfg_parity;
            r_stop2   <= cfg_stop2;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_decide && w_maj) r_state <= ST_IDLE;
          else if (w_bit_end)    r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_decide) r_shift <= {w_maj, r_shift[7:1]};
          if (w_bit_end) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == ({1'b0, r_bits} + 3'd4))
              r_state <= ((r_par == PAR_EVEN) || (r_par == PAR_ODD)) ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          if (w_decide)  r_perr  <= w_maj ^ (^r_shift) ^ r_par[0];
          if (w_bit_end) r_state <= ST_STOP1;
        end
        ST_STOP1: begin
          if (w_decide) begin
            r_ferr <= ~w_maj;
            if (!r_stop2) r_state <= ST_IDLE;
          end else if (w_bit_end) begin
            r_state <= ST_STOP2;
          end
        end
        ST_STOP2: begin
          if (w_decide) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_fifo #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (rd_en),
    .o_data  (rd_data),
    .o_count (count),
    .o_empty (empty),
    .o_full  (full)
  );

  // A new overrun beats a clear in the same cycle.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)                r_overrun <= 1'b0;
    else if (w_push && full && !rd_en) r_overrun <= 1'b1;
    else if (clr_overrun)              r_overrun <= 1'b0;
  end
  assign overrun = r_overrun;

`ifdef UART_RX_TIMEOUT_EN
  localparam int c_bpw = 16 + c_tw + 1;
  localparam logic [5:0] c_to_lim = 6'(RX_TIMEOUT_BITS);

  logic [c_bpw-1:0] r_to_clk;
  logic [5:0]       r_to_bits;
  logic             r_timeout;
  logic [c_bpw-1:0] w_bp_last;
  logic             w_to_run;

  assign w_bp_last = c_bpw'(OVERSAMPLE) * (c_bpw'(cfg_clk_div) + c_bpw'(1)) - c_bpw'(1);
  assign w_to_run  = !empty && (r_state == ST_IDLE) && (r_to_bits != c_to_lim);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_to_clk  <= '0;
      r_to_bits <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_push || (rd_en && !empty)) begin
        r_to_clk  <= '0;
        r_to_bits <= '0;
      end else if (w_to_run) begin
        if (r_to_clk == w_bp_last) begin
          r_to_clk  <= '0;
          r_to_bits <= r_to_bits + 6'd1;
        end else begin
          r_to_clk <= r_to_clk + c_bpw'(1);
        end
      end
      if (rd_en || w_push)
        r_timeout <= 1'b0;
      else if (w_to_run && (r_to_clk == w_bp_last) && (r_to_bits == c_to_lim - 6'd1))
        r_timeout <= 1'b1;
    end
  end
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign irq = ((count >= cfg_irq_thresh) && (cfg_irq_thresh != '0)) | r_overrun | timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_uart_rx_core : table-driven frames with a scoreboard queue of entries   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_rx_core;

  localparam int DEPTH = 2;
  localparam int OS    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] cfg_clk_div = '0;
  logic [1:0]  cfg_data_bits = 2'd3;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic [1:0]  cfg_irq_thresh = 2'd1;
  logic        rd_en = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [9:0]  rd_data;
  logic [1:0]  count;
  logic        empty, full, overrun, timeout, irq;

  uart_rx_core #(.DEPTH(DEPTH), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rst_n),
    .rx             (rx),
    .cfg_clk_div    (cfg_clk_div),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity     (cfg_parity),
    .cfg_stop2      (cfg_stop2),
    .cfg_irq_thresh (cfg_irq_thresh),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .overrun        (overrun),
    .clr_overrun    (clr_overrun),
    .timeout        (timeout),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] bits;
    logic [1:0] par;
    logic       stop2;
    logic       flip_par;
    logic       bad_stop1;
    logic       bad_stop2;
    int         div;
    logic [9:0] exp;
  } vec_t;

  vec_t       vecs [8];
  logic [9:0] q [$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one frame bit-by-bit from a negedge; rd_en pulses on clock index rd_at.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] bits, input logic [1:0] par,
                            input logic st2, input logic flip, input logic bad1, input logic bad2,
                            input int div, input int rd_at, input int idle_bits);
    logic fb [$];
    logic p;
    int   bp;
    int   c;
    cfg_clk_div   = 16'(div);
    cfg_data_bits = bits;
    cfg_parity    = par;
    cfg_stop2     = st2;
    p = par[0] ^ flip;
    fb.push_back(1'b0);
    for (int i = 0; i < int'(bits) + 5; i++) begin
      fb.push_back(d[i]);
      p ^= d[i];
    end
    if (par[1]) fb.push_back(p);
    fb.push_back(~bad1);
    if (st2) fb.push_back(~bad2);
    bp = OS * (div + 1);
    c  = 0;
    foreach (fb[j]) begin
      repeat (bp) begin
        rx    = fb[j];
        rd_en = (c == rd_at);
        @(negedge clk);
        c++;
      end
    end
    rd_en = 1'b0;
    rx    = 1'b1;
    repeat (idle_bits * bp) @(negedge clk);
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    int k;
    k = 0;
    while ((int'(count) != target) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check({name, "_count"}, 32'(count), 32'(target));
  endtask

  task automatic pop_check(input string name);
    if (q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, rd_data);
    end else begin
      check(name, 32'(rd_data), 32'(q.pop_front()));
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 10'h0A5};
    vecs[1] = '{8'h3C, 2'd2, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 0, 10'h23C};
    vecs[2] = '{8'h41, 2'd3, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 10'h141};
    vecs[3] = '{8'hFF, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2, 10'h01F};
    vecs[4] = '{8'h2A, 2'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 10'h02A};
    vecs[5] = '{8'h80, 2'd3, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 0, 10'h180};
    vecs[6] = '{8'hC5, 2'd3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 0, 10'h0C5};
    vecs[7] = '{8'h5B, 2'd3, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 0, 10'h35B};

    repeat (3) @(negedge clk);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_count",   32'(count),   0);
    check("rst_empty",   32'(empty),   1);
    check("rst_full",    32'(full),    0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_irq",     32'(irq),     0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) begin
      q.push_back(vecs[i].exp);
      send_frame(vecs[i].data, vecs[i].bits, vecs[i].par, vecs[i].stop2, vecs[i].flip_par,
                 vecs[i].bad_stop1, vecs[i].bad_stop2, vecs[i].div, -1, 2);
      wait_count(1, 400, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_irq", i), 32'(irq), 1);
      pop_check($sformatf("vec%0d_data", i));
      check($sformatf("vec%0d_empty", i), 32'(empty), 1);
    end

    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("pop_empty_count", 32'(count), 0);
    check("pop_empty_empty", 32'(empty), 1);

    q.push_back(10'h05A);
    send_frame(8'h5A, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    wait_count(1, 400, "thresh");
    cfg_irq_thresh = 2'd0;
    #1 check("irq_thresh0", 32'(irq), 0);
    cfg_irq_thresh = 2'd2;
    #1 check("irq_thresh2", 32'(irq), 0);
    cfg_irq_thresh = 2'd1;
    @(negedge clk);
    pop_check("thresh_data");

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    check("false_start_count", 32'(count), 0);
    check("false_start_empty", 32'(empty), 1);
    q.push_back(10'h0C3);
    send_frame(8'hC3, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    wait_count(1, 400, "after_false");
    pop_check("after_false_data");

    q.push_back(10'h000);
    q.push_back(10'h011);
    send_frame(8'h00, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    send_frame(8'h11, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    send_frame(8'h22, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    check("ovr_count",   32'(count),   2);
    check("ovr_full",    32'(full),    1);
    check("ovr_overrun", 32'(overrun), 1);
    pop_check("ovr_pop0");
    pop_check("ovr_pop1");
    check("ovr_drained", 32'(count), 0);
    check("ovr_sticky",  32'(overrun), 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);
    check("ovr_irq_low", 32'(irq), 0);

    // Third frame's push lands at clock index 2 + (16*9 + 10) = 156 of the frame.
    q.push_back(10'h033);
    q.push_back(10'h044);
    send_frame(8'h33, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    send_frame(8'h44, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    check("sim_full_before", 32'(full), 1);
    check("sim_head", 32'(rd_data), 32'(q.pop_front()));
    q.push_back(10'h066);
    send_frame(8'h66, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 156, 2);
    check("sim_count",   32'(count),   2);
    check("sim_overrun", 32'(overrun), 0);
    pop_check("sim_pop0");
    pop_check("sim_pop1");

    send_frame(8'h12, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    send_frame(8'h13, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    send_frame(8'h14, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    check("pre_rst_overrun", 32'(overrun), 1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count",   32'(count),   0);
    check("mid_rst_empty",   32'(empty),   1);
    check("mid_rst_full",    32'(full),    0);
    check("mid_rst_overrun", 32'(overrun), 0);
    check("mid_rst_rd_data", 32'(rd_data), 0);
    check("mid_rst_irq",     32'(irq),     0);
    check("mid_rst_timeout", 32'(timeout), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();
    q.push_back(10'h055);
    send_frame(8'h55, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    wait_count(1, 400, "post_rst");
    pop_check("post_rst_data");

    q.push_back(10'h07E);
`ifdef UART_RX_TIMEOUT_EN
    fork
      send_frame(8'h7E, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 0);
      begin
        int k;
        k = 0;
        while ((count != 2'd1) && (k < 400)) begin
          @(negedge clk);
          k++;
        end
        check("to_push_seen", 32'(count), 1);
        repeat (40 * OS - 1) @(negedge clk);
        check("to_before", 32'(timeout), 0);
        @(negedge clk);
        check("to_at_40", 32'(timeout), 1);
        check("to_irq", 32'(irq), 1);
      end
    join
`else
    send_frame(8'h7E, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 2);
    wait_count(1, 400, "to_off");
    repeat (45 * OS) @(negedge clk);
    check("to_disabled", 32'(timeout), 0);
`endif
    pop_check("to_data");
    check("to_cleared", 32'(timeout), 0);
    check("to_empty",   32'(empty),   1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive engine with oversampled majority-vote sampling, runtime-programmable frame format, error tagging and a first-word-fall-through receive FIFO. Successor to the fixed 8N1 receive path of the AXI UART IP. It sits between the `rx` pin and the AXI-lite register file, which drives the configuration inputs and pops the FIFO on RX_BUFF reads.

## Interface

**Parameters**
- `DEPTH`, default 4: number of FIFO entries; must be 2 or more.
- `OVERSAMPLE`, default 16: sample ticks per bit; must be even and 8 or more.
- `SYNC_STAGES`, default 2: flip-flop stages in the `rx` synchroniser.

**Ports** (clock and reset first)
- `s_axi_aclk` in 1: the single clock.
- `s_axi_aresetn` in 1: reset, asynchronous, active-low.
- `rx` in 1: serial input; idle level is high.
- `cfg_clk_div` in 16: one sample tick every `cfg_clk_div+1` clocks.
- `cfg_data_bits` in 2: word length; 0 selects 5 bits, 1 selects 6, 2 selects 7, 3 selects 8.
- `cfg_parity` in 2: 0x means none, 10 means even, 11 means odd.
- `cfg_stop2` in 1: 1 selects two stop bits.
- `cfg_irq_thresh` in $clog2(DEPTH+1): FIFO fill level at which the level interrupt asserts.
- `rd_en` in 1: pop the head entry.
- `rd_data` out 10: head entry, {parity_err, frame_err, data[7:0]}; data is zero-extended.
- `count` out $clog2(DEPTH+1): number of occupied entries.
- `empty` out 1, `full` out 1: FIFO status.
- `overrun` out 1: sticky; set when a frame completes while the FIFO is full.
- `clr_overrun` in 1: clears `overrun`.
- `timeout` out 1: receive-timeout flag (see Configuration).
- `irq` out 1: `(count >= cfg_irq_thresh && cfg_irq_thresh != 0) | overrun | timeout`.

## Operation

- **Synchroniser and glitch filter.** `rx` passes through `SYNC_STAGES` flip-flops. The synchroniser reset value is 1.
- **Tick generator.** A divider counts `0..cfg_clk_div` and emits a 1-clock tick at wrap. It is held at 0 while the FSM is IDLE, so the first tick comes `cfg_clk_div+1` clocks after the falling edge is detected.
- **FSM states.** IDLE, START, DATA, PARITY, STOP1, STOP2.
  - **IDLE.** On synchronised `rx`=0, latch all `cfg_*` inputs into frame registers and go to START. Configuration changes mid-frame have no effect on that frame.
  - **Bit sampling.** Each bit lasts `OVERSAMPLE` ticks. The bit value is the majority of the samples at ticks `OVERSAMPLE/2-1`, `OVERSAMPLE/2` and `OVERSAMPLE/2+1`.
  - **START.** If the majority is 1 (false start), go to IDLE and push nothing. Otherwise go to DATA.
  - **DATA.** Shift bits in LSB first, `cfg_data_bits+5` bits in total. Then go to PARITY if parity is enabled, else STOP1.
  - **PARITY.** `parity_err` = received bit differs from the expected value. Even: XOR of data bits. Odd: inverse of that XOR.
  - **STOP1.** `frame_err` = majority is 0. Then go to STOP2 if `cfg_stop2` is set, else push and return to IDLE.
  - **STOP2.** `frame_err` is ORed with this bit's check. Then push and return to IDLE.
  - **Early return.** Return to IDLE happens at the centre of the last stop bit, not at its end, so back-to-back frames are tolerated.
- **Push.**
  - If not full, the entry is written at the tail.
  - If full and `rd_en` is not active, the frame is dropped and `overrun` is set.
  - If full and `rd_en` is active in the same cycle, pop and push both occur, `count` is unchanged and there is no overrun.
- **Pop.** `rd_en` while empty is ignored. Pointers wrap modulo `DEPTH`, so `DEPTH` does not need to be a power of two.
- **Overrun precedence.** If `clr_overrun` and a new overrun occur in the same cycle, set wins.
- **Reset values.** `rd_data`=0, `count`=0, `empty`=1, `full`=0, `overrun`=0, `timeout`=0, `irq`=0, FSM=IDLE. A reset mid-frame discards the partial frame and all FIFO contents.

## Timing

- Bit period = `OVERSAMPLE*(cfg_clk_div+1)` clocks.
- Push: `count`, `empty`, `full` and `rd_data` update on the clock edge after the final stop-bit majority sample.
- Pop: `rd_en` sampled high at edge N gives the next entry on `rd_data` and `count-1` after edge N. This is FWFT with no read latency.
- `irq` is combinational from registered flags and has no extra delay.
- Input latency is `SYNC_STAGES` clocks from the `rx` pin to FSM visibility.

## Configuration

- **`UART_RX_TIMEOUT_EN` defined.**
  - A counter advances once per bit period while `empty`=0 and the FSM is IDLE.
  - It clears on any push or pop.
  - `timeout` sets when the counter reaches 40 bit periods.
  - `timeout` clears on `rd_en` or on a push.
- **Not defined.** `timeout` is tied to 0 and the counter is not built.

## Structure

- **Package `uart_pkg`:**
  - FSM state enum.
  - Parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`.
  - Entry field positions `RX_PERR_BIT`=9 and `RX_FERR_BIT`=8.
  - Timeout length constant `RX_TIMEOUT_BITS`=40.
- **Sub-module `uart_fifo`:** generic FWFT FIFO with parameters `WIDTH` and `DEPTH`, supporting simultaneous push and pop. The transmit path reuses it.

## Test plan

1. **8N1 byte.** `cfg_clk_div`=0, `OVERSAMPLE`=16. Send 0xA5 as 8N1 → `rd_data`=0x0A5, `count`=1, `irq`=1 with threshold 1.
2. **7-bit even parity.** Send 0x3C as 7E1 with the parity bit inverted → `rd_data`=0x23C (`parity_err` set). Then 0x41 as 8O2 with the second stop bit low → `rd_data`=0x141 (`frame_err` set).
3. **False start.** A 4-clock low glitch on `rx` → no push, `count`=0, FSM back in IDLE.
4. **Overrun.** With `DEPTH`=2, send 0x00, 0x11, 0x22 with no reads → `count`=2, `overrun`=1, pops return 0x000 then 0x011. `clr_overrun` → `overrun`=0.
5. **Simultaneous push/pop and reset.** FIFO full, with `rd_en` asserted exactly on the push cycle → `count` stays 2 and `overrun`=0. Assert `s_axi_aresetn`=0 mid-frame → all outputs at reset values, and the next clean frame 0x55 is received correctly.
6. **Timeout (`UART_RX_TIMEOUT_EN`).** One byte 0x7E, then idle → `timeout`=1 exactly 40 bit periods after the push. `rd_en` → `timeout`=0, `empty`=1.
